// File: rtl/arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared sizes, state encoding and defaults for rr_arbiter8.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

   localparam int ARB_NREQ     = 8;
   localparam int ARB_IDX_W    = 3;
   localparam int ARB_HOLD_MAX = 16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/grant_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : grant_decode
// Brief    : 3-to-8 one-hot decoder with enable; all zeros when disabled.
// Revision : 1.0 - initial release
// ============================================================================
module grant_decode
   import arb_pkg::*;
(
   input  logic [ARB_IDX_W-1:0] i_idx,
   input  logic                 i_en,
   output logic [ARB_NREQ-1:0]  o_onehot
);

   generate
      for (genvar i = 0; i < ARB_NREQ; i++) begin : g_bit
         assign o_onehot[i] = i_en && (i_idx == ARB_IDX_W'(i));
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8
// Brief    : 8-way round-robin arbiter, registered winner index, one-hot grant.
//            Optional forced release after HOLD_MAX cycles: ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int NREQ     = ARB_NREQ,
   parameter int HOLD_MAX = ARB_HOLD_MAX,
   parameter int CW       = 5
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   output logic [NREQ-1:0]      gnt,
   output logic [ARB_IDX_W-1:0] gnt_idx,
   output logic                 gnt_valid,
   output logic                 timeout
);

   generate
      if (NREQ != ARB_NREQ || (2 ** CW) <= HOLD_MAX) begin : g_bad_param
         $error("rr_arbiter8: NREQ must be 8 and 2**CW must exceed HOLD_MAX");
      end
   endgenerate

   arb_state_t           r_state;
   arb_state_t           w_state_nxt;
   logic [ARB_IDX_W-1:0] r_gnt_idx;
   logic [ARB_IDX_W-1:0] w_idx_nxt;
   logic [ARB_IDX_W-1:0] r_ptr;
   logic [ARB_IDX_W-1:0] w_ptr_nxt;
   logic [ARB_IDX_W-1:0] w_winner;
   logic [ARB_IDX_W-1:0] w_cand;
   logic                 w_found;
   logic                 w_gnt_valid;

`ifdef ARB_TIMEOUT_EN
   localparam logic [CW-1:0] c_hold_last = CW'(HOLD_MAX - 1);

   logic [CW-1:0] r_hold_cnt;
   logic [CW-1:0] w_hold_nxt;
   logic          r_timeout;
   logic          w_timeout_nxt;
`endif

   // Scan upward from ptr with 3-bit wrap; the last owner sits at ptr-1 so it loses ties.
   always_comb begin
      w_winner = r_ptr;
      w_cand   = r_ptr;
      w_found  = 1'b0;
      for (int k = 0; k < ARB_NREQ; k++) begin
         w_cand = r_ptr + ARB_IDX_W'(k);
         if (!w_found && req[w_cand]) begin
            w_winner = w_cand;
            w_found  = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_gnt_idx;
      w_ptr_nxt   = r_ptr;
`ifdef ARB_TIMEOUT_EN
      w_hold_nxt    = r_hold_cnt;
      w_timeout_nxt = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
`ifdef ARB_TIMEOUT_EN
            w_hold_nxt = '0;
`endif
            if (|req) begin
               w_state_nxt = ST_GRANT;
               w_idx_nxt   = w_winner;
            end
         end
         ST_GRANT: begin
`ifdef ARB_TIMEOUT_EN
            w_hold_nxt = r_hold_cnt + CW'(1);
`endif
            if (!req[r_gnt_idx]) begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = r_gnt_idx + ARB_IDX_W'(1);
            end
`ifdef ARB_TIMEOUT_EN
            // A voluntary release on the expiry cycle wins and suppresses the pulse.
            else if (r_hold_cnt == c_hold_last) begin
               w_state_nxt   = ST_IDLE;
               w_ptr_nxt     = r_gnt_idx + ARB_IDX_W'(1);
               w_timeout_nxt = 1'b1;
            end
`endif
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_gnt_idx <= '0;
         r_ptr     <= '0;
`ifdef ARB_TIMEOUT_EN
         r_hold_cnt <= '0;
         r_timeout  <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_gnt_idx <= w_idx_nxt;
         r_ptr     <= w_ptr_nxt;
`ifdef ARB_TIMEOUT_EN
         r_hold_cnt <= w_hold_nxt;
         r_timeout  <= w_timeout_nxt;
`endif
      end
   end

   assign w_gnt_valid = (r_state == ST_GRANT);
   assign gnt_valid   = w_gnt_valid;
   assign gnt_idx     = r_gnt_idx;

`ifdef ARB_TIMEOUT_EN
   assign timeout = r_timeout;
`else
   assign timeout = 1'b0;
`endif

   grant_decode u_grant_decode (
      .i_idx    (r_gnt_idx),
      .i_en     (w_gnt_valid),
      .o_onehot (gnt)
   );

endmodule
`default_nettype wire
